// File: rtl/fx_pt_sub_rnd_pipe.sv
// Two-stage pipelined fixed-point subtractor: diff = round-half-away(a - b) to SFW fraction bits,
// with valid/ready handshaking on both sides. SN selects unsigned, two's complement or sign-magnitude.
module fx_pt_sub_rnd_pipe #(
    parameter int unsigned SN  = 1,
    parameter int unsigned AIW = 2,
    parameter int unsigned AFW = 10,
    parameter int unsigned BIW = 4,
    parameter int unsigned BFW = 8,
    parameter int unsigned SFW = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [AIW+AFW-1:0]                            in_a,
    input  logic [BIW+BFW-1:0]                            in_b,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [((AIW > BIW) ? AIW : BIW)+2+SFW-1:0]    diff,
    output logic                                          uflow
);

    localparam int unsigned AW   = AIW + AFW;
    localparam int unsigned BW   = BIW + BFW;
    localparam int unsigned DIW  = ((AIW > BIW) ? AIW : BIW) + 2;
    localparam int unsigned TFW  = (AFW > BFW) ? AFW : BFW;
    localparam int unsigned FW   = (TFW > SFW + 1) ? TFW : SFW + 1;
    localparam int unsigned EW   = DIW + FW;
    localparam int unsigned DW   = DIW + SFW;
    localparam int unsigned RS   = FW - SFW;
    localparam int unsigned SHA  = FW - AFW;
    localparam int unsigned SHB  = FW - BFW;
    localparam logic [EW:0] HALF = (EW+1)'(1) << (RS - 1);

    logic          s1_valid_q, s1_valid_d;
    logic [EW-1:0] a_q, a_d, b_q, b_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] diff_q, diff_d;
    logic          uflow_q, uflow_d;

    logic          s2_load, accept;
    logic [AW-1:0] a_raw;
    logic [BW-1:0] b_raw;
    logic [EW-1:0] a_al, b_al, a_ext, b_ext;
    logic [EW-1:0] sub, mag;
    logic [EW:0]   rnd;
    logic [DW-1:0] rmag;
    logic          neg;

    // Both stages advance whenever the output register is free or being drained.
    always_comb begin
        s2_load  = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;
        accept   = in_valid && in_ready;
    end

    // Stage 1: align both operands to a common two's-complement EW-bit grid.
    always_comb begin
        a_raw = in_a;
        b_raw = in_b;
        if (SN == 2) begin
            a_raw[AW-1] = 1'b0;
            b_raw[BW-1] = 1'b0;
        end
        a_ext = {{(EW-AW){(SN == 1) && in_a[AW-1]}}, a_raw} << SHA;
        b_ext = {{(EW-BW){(SN == 1) && in_b[BW-1]}}, b_raw} << SHB;
        a_al  = ((SN == 2) && in_a[AW-1]) ? -a_ext : a_ext;
        b_al  = ((SN == 2) && in_b[BW-1]) ? -b_ext : b_ext;

        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        a_d        = accept ? a_al : a_q;
        b_d        = accept ? b_al : b_q;
    end

    // Stage 2: subtract, round the magnitude half-away-from-zero, re-encode per format.
    always_comb begin
        sub  = a_q - b_q;
        neg  = sub[EW-1];
        mag  = neg ? -sub : sub;
        rnd  = {1'b0, mag} + HALF;
        rmag = DW'(rnd >> RS);

        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        uflow_d     = uflow_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                uflow_d = 1'b0;
                if (SN == 0) begin
                    diff_d  = neg ? '0 : rmag;
                    uflow_d = neg;
                end else if (SN == 2) begin
                    // A magnitude that rounds to zero is always emitted as +0.
                    diff_d = {neg && (rmag != '0), rmag[DW-2:0]};
                end else begin
                    diff_d = neg ? -rmag : rmag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            uflow_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            uflow_q     <= uflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign uflow     = uflow_q;

endmodule

// File: tb/tb_fx_pt_sub_rnd_pipe.sv
// Bench for fx_pt_sub_rnd_pipe: one instance per SN format fed the same stream, checked by a
// scoreboard against an integer model of real-valued a - b rounded half-away-from-zero.
module tb_fx_pt_sub_rnd_pipe;

    localparam int AIW = 2, AFW = 10, BIW = 4, BFW = 8, SFW = 3;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [11:0] in_a, in_b;
    logic [2:0]  in_rdy, out_vld, uf_o;
    logic [8:0]  diff_o [3];

    int          n_chk = 0, n_fail = 0;
    logic [29:0] exp_log [$];
    int          rd_idx [3] = '{0, 0, 0};
    logic        hold_v [3] = '{1'b0, 1'b0, 1'b0};
    logic [9:0]  hold_val [3];
    bit          rnd_done;

    always #5 clk = ~clk;

    fx_pt_sub_rnd_pipe #(.SN(0), .AIW(AIW), .AFW(AFW), .BIW(BIW), .BFW(BFW), .SFW(SFW)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_a(in_a), .in_b(in_b),
        .out_valid(out_vld[0]), .out_ready(out_ready), .diff(diff_o[0]), .uflow(uf_o[0]));
    fx_pt_sub_rnd_pipe #(.SN(1), .AIW(AIW), .AFW(AFW), .BIW(BIW), .BFW(BFW), .SFW(SFW)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_a(in_a), .in_b(in_b),
        .out_valid(out_vld[1]), .out_ready(out_ready), .diff(diff_o[1]), .uflow(uf_o[1]));
    fx_pt_sub_rnd_pipe #(.SN(2), .AIW(AIW), .AFW(AFW), .BIW(BIW), .BFW(BFW), .SFW(SFW)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_a(in_a), .in_b(in_b),
        .out_valid(out_vld[2]), .out_ready(out_ready), .diff(diff_o[2]), .uflow(uf_o[2]));

    function automatic void check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (SN=%0d) at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endfunction

    // Real-valued reference: operands as integers in units of 2^-AFW, result to nearest 2^-SFW.
    function automatic logic [9:0] model(int sn, logic [11:0] a, logic [11:0] b);
        longint av, bv, x, m, r;
        logic [8:0] d;
        logic       u;
        av = longint'(a);
        bv = longint'(b);
        if (sn == 1) begin
            if (a[11]) av = av - 4096;
            if (b[11]) bv = bv - 4096;
        end else if (sn == 2) begin
            av = a[11] ? -longint'(a[10:0]) : longint'(a[10:0]);
            bv = b[11] ? -longint'(b[10:0]) : longint'(b[10:0]);
        end
        x = av - bv * (longint'(1) << (AFW - BFW));
        m = (x < 0) ? -x : x;
        r = (m + (longint'(1) << (AFW - SFW - 1))) / (longint'(1) << (AFW - SFW));
        u = 1'b0;
        if (sn == 0) begin
            d = (x < 0) ? 9'd0 : 9'(r);
            u = (x < 0);
        end else if (sn == 1) begin
            d = 9'((x < 0) ? -r : r);
        end else begin
            d = {(x < 0) && (r != 0), 8'(r)};
        end
        return {u, d};
    endfunction

    function automatic bit drained();
        return rd_idx[0] == exp_log.size() && rd_idx[1] == exp_log.size() &&
               rd_idx[2] == exp_log.size();
    endfunction

    function automatic logic [11:0] pick();
        logic [11:0] corners [6];
        corners = '{12'h000, 12'h7FF, 12'h800, 12'hFFF, 12'h001, 12'h400};
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 5)];
        return 12'($urandom);
    endfunction

    // Scoreboard: compare outputs and stall stability, then log newly accepted operands.
    always @(negedge clk) begin
        logic [29:0] e;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                rd_idx[k] = exp_log.size();
                hold_v[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (hold_v[k]) begin
                    check("stall_valid_kept", k, 32'(out_vld[k]), 32'd1);
                    if (out_vld[k]) check("stall_hold", k, 32'({uf_o[k], diff_o[k]}), 32'(hold_val[k]));
                end
                if (out_vld[k] && out_ready) begin
                    if (rd_idx[k] < exp_log.size()) begin
                        e = exp_log[rd_idx[k]];
                        check("result", k, 32'({uf_o[k], diff_o[k]}), 32'(e[k*10 +: 10]));
                        rd_idx[k]++;
                    end else begin
                        check("spurious_out", k, 32'(out_vld[k]), 32'd0);
                    end
                    hold_v[k] = 1'b0;
                end else if (out_vld[k]) begin
                    hold_v[k]   = 1'b1;
                    hold_val[k] = {uf_o[k], diff_o[k]};
                end else begin
                    hold_v[k] = 1'b0;
                end
            end
            if (in_valid && in_rdy[0])
                exp_log.push_back({model(2, in_a, in_b), model(1, in_a, in_b), model(0, in_a, in_b)});
        end
    end

    task automatic send(input logic [11:0] a, input logic [11:0] b);
        bit ok = 1'b0;
        int c = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!ok && c < 200) begin
            @(negedge clk);
            ok = in_rdy[0] && !rst;
            @(posedge clk);
            #1;
            c++;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", c);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        out_ready = 1'b1;
        while (!drained() && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_chk++;
        if (!drained()) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d/%0d of %0d results seen, required all",
                     rd_idx[0], rd_idx[1], rd_idx[2], exp_log.size());
        end
    endtask

    typedef struct packed {
        logic [1:0]  sn;
        logic [11:0] a;
        logic [11:0] b;
        logic [8:0]  d;
        logic        u;
    } dir_t;

    dir_t dir_tab [8];

    initial begin
        dir_tab = '{
            '{2'd1, 12'h400, 12'h0C0, 9'h002, 1'b0},
            '{2'd1, 12'h040, 12'h000, 9'h001, 1'b0},
            '{2'd1, 12'h000, 12'h010, 9'h1FF, 1'b0},
            '{2'd1, 12'h7FF, 12'h800, 9'h050, 1'b0},
            '{2'd0, 12'h000, 12'h100, 9'h000, 1'b1},
            '{2'd0, 12'h400, 12'h000, 9'h008, 1'b0},
            '{2'd2, 12'h800, 12'h800, 9'h000, 1'b0},
            '{2'd2, 12'h400, 12'h900, 9'h010, 1'b0}};
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        rnd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_out_valid", k, 32'(out_vld[k]), 32'd0);
            check("reset_diff", k, 32'(diff_o[k]), 32'd0);
            check("reset_uflow", k, 32'(uf_o[k]), 32'd0);
            check("reset_in_ready", k, 32'(in_rdy[k]), 32'd1);
        end
        @(posedge clk);
        #1;

        // Directed vectors: exact values and two-edge latency.
        for (int i = 0; i < 8; i++) begin
            int k;
            k = int'(dir_tab[i].sn);
            send(dir_tab[i].a, dir_tab[i].b);
            @(negedge clk);
            check("latency_early", k, 32'(out_vld[k]), 32'd0);
            @(negedge clk);
            check("latency_valid", k, 32'(out_vld[k]), 32'd1);
            check("dir_diff", k, 32'(diff_o[k]), 32'(dir_tab[i].d));
            check("dir_uflow", k, 32'(uf_o[k]), 32'(dir_tab[i].u));
            @(posedge clk);
            #1;
        end
        drain();

        // Backpressure: two entries absorbed, then in_ready drops until out_ready returns.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(12'($urandom), 12'($urandom));
            end
            begin
                @(negedge clk);
                check("stall_ready_1st", 0, 32'(in_rdy[0]), 32'd1);
                @(negedge clk);
                check("stall_ready_2nd", 0, 32'(in_rdy[0]), 32'd1);
                @(negedge clk);
                check("stall_ready_full", 0, 32'(in_rdy[0]), 32'd0);
                repeat (2) @(negedge clk);
                check("stall_ready_still_full", 0, 32'(in_rdy[0]), 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a stream discards in-flight data.
        fork
            begin
                for (int i = 0; i < 6; i++) send(12'($urandom), 12'($urandom));
            end
            begin
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    check("post_reset_out_valid", k, 32'(out_vld[k]), 32'd0);
                    check("post_reset_in_ready", k, 32'(in_rdy[k]), 32'd1);
                end
            end
        join
        drain();

        // Random operands with random downstream backpressure.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    send(pick(), pick());
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
